// File: rtl/emergency_preempt_arbiter.sv
// Round-robin arbiter for four emergency preemption requests (N,E,S,W) driving one trigger.
// Each request is debounced, held between min/max limits, and followed by a cooldown.
module emergency_preempt_arbiter #(
    parameter int DEBOUNCE_S = 2,
    parameter int MIN_HOLD_S = 4,
    parameter int MAX_HOLD_S = 30,
    parameter int COOLDOWN_S = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [3:0] req,
    input  logic       system_fault,
    output logic       emergency_trigger,
    output logic [3:0] grant,
    output logic       grant_ns,
    output logic       timeout_pulse,
    output logic [3:0] lockout,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CONFIRM  = 2'd1,
        S_GRANT    = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    localparam logic [6:0] DEB_L  = 7'(DEBOUNCE_S);
    localparam logic [6:0] MIN_L  = 7'(MIN_HOLD_S);
    localparam logic [6:0] MAX_L  = 7'(MAX_HOLD_S);
    localparam logic [6:0] COOL_L = 7'(COOLDOWN_S);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt, cnt_sat;
    logic [6:0] cnt_inc;
    logic [1:0] cand, cand_nxt;
    logic [1:0] rr_ptr, rr_ptr_nxt;
    logic [1:0] pick, idx;
    logic       pick_vld;
    logic [3:0] elig, lock_set, lockout_nxt;
    logic       timeout_nxt;
    logic       exit_grant;

    assign elig      = req & ~lockout;
    assign cnt_inc   = {1'b0, cnt} + 7'd1;
    assign cnt_sat   = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    assign state_dbg = state;

    // Walk offsets from far to near so the nearest eligible requester after rr_ptr wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (elig[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        rr_ptr_nxt  = rr_ptr;
        lock_set    = 4'd0;
        timeout_nxt = 1'b0;
        exit_grant  = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    cand_nxt  = pick;
                    cnt_nxt   = 6'd0;
                    state_nxt = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (!req[cand]) begin
                    cnt_nxt   = 6'd0;
                    state_nxt = S_IDLE;
                end else if (tick_1hz) begin
                    if (cnt_inc >= DEB_L) begin
                        cnt_nxt   = 6'd0;
                        state_nxt = S_GRANT;
                    end else begin
                        cnt_nxt = cnt_sat;
                    end
                end
            end
            S_GRANT: begin
                if (tick_1hz && cnt_inc >= MAX_L) begin
                    lock_set[cand] = 1'b1;
                    timeout_nxt    = 1'b1;
                    exit_grant     = 1'b1;
                end else if (!req[cand] && {1'b0, cnt} >= MIN_L) begin
                    exit_grant = 1'b1;
                end else if (tick_1hz) begin
                    cnt_nxt = cnt_sat;
                end
                if (exit_grant) begin
                    rr_ptr_nxt = cand + 2'd1;
                    cnt_nxt    = 6'd0;
                    state_nxt  = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (tick_1hz) begin
                    if (cnt_inc >= COOL_L) begin
                        cnt_nxt   = 6'd0;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = cnt_sat;
                    end
                end
            end
            default: begin
                cnt_nxt   = 6'd0;
                state_nxt = S_IDLE;
            end
        endcase

        // A fault abandons whatever is in flight but keeps fairness and lockout history.
        if (system_fault) begin
            state_nxt   = S_IDLE;
            cnt_nxt     = 6'd0;
            cand_nxt    = cand;
            rr_ptr_nxt  = rr_ptr;
            lock_set    = 4'd0;
            timeout_nxt = 1'b0;
        end
    end

    assign lockout_nxt = lock_set | (lockout & req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            cnt               <= 6'd0;
            cand              <= 2'd0;
            rr_ptr            <= 2'd0;
            lockout           <= 4'd0;
            emergency_trigger <= 1'b0;
            grant             <= 4'd0;
            grant_ns          <= 1'b0;
            timeout_pulse     <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            cand              <= cand_nxt;
            rr_ptr            <= rr_ptr_nxt;
            lockout           <= lockout_nxt;
            emergency_trigger <= (state_nxt == S_GRANT);
            grant             <= (state_nxt == S_GRANT) ? (4'd1 << cand_nxt) : 4'd0;
            grant_ns          <= (state_nxt == S_GRANT) && !cand_nxt[0];
            timeout_pulse     <= timeout_nxt;
        end
    end

endmodule
